// File: rtl/robot_cmd_arbiter.sv
// Prioritised motor-command arbiter: per-source command latches and hold timers, plus a proximity safety FSM.
// Optional ARB_PROX_REVERSE_EN: let a live REVERSE_CMD winner drive the motors while blocked or recovering.
module robot_cmd_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int CMD_W        = 5,
    parameter int HOLD_CYCLES  = 25_000_000,
    parameter int BLOCK_CYCLES = 5_000_000,
    parameter logic [CMD_W-1:0] STOP_CMD    = '0,
    parameter logic [CMD_W-1:0] REVERSE_CMD = CMD_W'(2),
    localparam int AW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*CMD_W-1:0] src_cmd,
    input  logic [NUM_SRC-1:0]       src_en,
    input  logic                     proximity,
    output logic [CMD_W-1:0]         motor_cmd,
    output logic [AW-1:0]            active_src,
    output logic                     cmd_valid,
    output logic                     timeout_flag,
    output logic [1:0]               arb_state
);
    localparam int TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int BW = (BLOCK_CYCLES > 0) ? $clog2(BLOCK_CYCLES + 1) : 1;
`ifdef ARB_PROX_REVERSE_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DRIVE   = 2'b01,
        BLOCKED = 2'b10,
        RECOVER = 2'b11
    } state_t;

    logic [TW-1:0]    timer_q [NUM_SRC];
    logic [CMD_W-1:0] latch_q [NUM_SRC];
    logic [NUM_SRC-1:0] expired_q;
    logic [NUM_SRC-1:0] live;
    logic             any_live;
    logic [AW-1:0]    win_idx;
    logic [CMD_W-1:0] win_cmd;
    logic             rev_hit;

    state_t           state_q, state_d;
    logic [BW-1:0]    rec_q, rec_d;
    logic [CMD_W-1:0] motor_q, motor_d;
    logic [AW-1:0]    active_q, active_d;
    logic             valid_q, valid_d;
    logic             tmo_q, tmo_d;

    // expired_q marks a natural 1->0 expiry so a src_en drop is never reported as a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                timer_q[i] <= '0;
                latch_q[i] <= STOP_CMD;
            end
            expired_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                expired_q[i] <= src_en[i] && !src_valid[i] && (timer_q[i] == TW'(1));
                if (!src_en[i]) begin
                    timer_q[i] <= '0;
                    latch_q[i] <= STOP_CMD;
                end else if (src_valid[i]) begin
                    timer_q[i] <= TW'(HOLD_CYCLES);
                    latch_q[i] <= src_cmd[i*CMD_W +: CMD_W];
                end else if (timer_q[i] != '0) begin
                    timer_q[i] <= timer_q[i] - TW'(1);
                end
            end
        end
    end

    always_comb begin
        win_idx = '0;
        win_cmd = STOP_CMD;
        for (int i = 0; i < NUM_SRC; i++) begin
            live[i] = (timer_q[i] != '0);
            if (live[i]) begin
                win_idx = AW'(i);
                win_cmd = latch_q[i];
            end
        end
        any_live = |live;
        rev_hit  = REV_EN && any_live && (win_cmd == REVERSE_CMD);
    end

    // Outputs are computed from the next state so they change on the same edge as arb_state.
    always_comb begin
        state_d  = state_q;
        rec_d    = rec_q;
        motor_d  = STOP_CMD;
        valid_d  = 1'b0;
        active_d = active_q;
        tmo_d    = (state_q == DRIVE) && expired_q[active_q];
        case (state_q)
            IDLE: begin
                if (proximity)     state_d = BLOCKED;
                else if (any_live) state_d = DRIVE;
            end
            DRIVE: begin
                if (proximity)      state_d = BLOCKED;
                else if (!any_live) state_d = IDLE;
            end
            BLOCKED: begin
                if (!proximity) begin
                    state_d = RECOVER;
                    rec_d   = BW'(BLOCK_CYCLES);
                end
            end
            RECOVER: begin
                if (proximity) begin
                    state_d = BLOCKED;
                end else if (rec_q <= BW'(1)) begin
                    rec_d   = '0;
                    state_d = any_live ? DRIVE : IDLE;
                end else begin
                    rec_d = rec_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DRIVE) begin
            motor_d  = win_cmd;
            active_d = win_idx;
            valid_d  = 1'b1;
        end else if ((state_d == BLOCKED || state_d == RECOVER) && rev_hit) begin
            motor_d = REVERSE_CMD;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rec_q    <= '0;
            motor_q  <= STOP_CMD;
            active_q <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rec_q    <= rec_d;
            motor_q  <= motor_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
        end
    end

    assign motor_cmd    = motor_q;
    assign active_src   = active_q;
    assign cmd_valid    = valid_q;
    assign timeout_flag = tmo_q;
    assign arb_state    = state_q;
endmodule
